seven_seg_scanner: RTL

Display back end for the stopwatch: consumes the 16-bit `Count` produced by the counter stage and drives a 4-digit, common-anode, time-multiplexed seven-segment display in decimal. A sequential shift-add-3 (double-dabble) converter samples `Count` every 18 cycles and produces BCD digits. A free-running refresh counter scans the digits. Values above 9999 display as four dashes.

---
 rtl/seven_seg_scanner.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: shows a 16-bit count in decimal on a 4-digit, common-anode,
// time-multiplexed seven-segment display, with leading-zero blanking and overflow dashes.
//
// Ports:
//   Clock        in   1   single clock, rising edge
//   Reset        in   1   synchronous, active-high reset
//   Count        in  16   unsigned binary value to display
//   Seg          out  7   segment drives, active low, Seg[0]=a .. Seg[6]=g
//   An           out  4   digit anode enables, active low, one-hot, An[0]=units
//
// Parameters:
//   REFRESH_BITS   refresh counter width; each digit is held 2^(REFRESH_BITS-2) cycles
//   BLANK_LEADING  nonzero blanks leading zeros (the units digit is always shown)

module seven_seg_scanner #(
    parameter int REFRESH_BITS  = 17,
    parameter int BLANK_LEADING = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] Count,
    output logic [6:0]  Seg,
    output logic [3:0]  An
);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [3:0] AN_RESET  = 4'b1110;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Converter state
    state_t      state_q, state_d;
    logic [15:0] bin_q, bin_d;
    logic [19:0] bcd_q, bcd_d;
    logic [19:0] bcd_adj;
    logic [3:0]  bit_q, bit_d;

    // Committed display value
    logic [15:0] disp_q, disp_d;
    logic        ovf_q, ovf_d;

    // Scan and output registers
    logic [REFRESH_BITS-1:0] ref_q;
    logic [1:0]  dig;
    logic [3:0]  nib;
    logic        lead_zero;
    logic [6:0]  seg_d, seg_q;
    logic [3:0]  an_d, an_q;

    // ------------------------------------------------------------------
    // Double-dabble: add 3 to every nibble >= 5 before each shift
    // ------------------------------------------------------------------
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // ------------------------------------------------------------------
    // Converter FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        bit_d   = bit_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            LOAD: begin
                bin_d   = Count;
                bcd_d   = '0;
                bit_d   = '0;
                state_d = SHIFT;
            end

            SHIFT: begin
                // The adjusted accumulator's MSB is provably zero for a
                // 16-bit input, so dropping it loses nothing.
                {bcd_d, bin_d} = {bcd_adj[18:0], bin_q, 1'b0};
                bit_d = bit_q + 4'd1;
                if (bit_q == 4'd15) begin
                    state_d = COMMIT;
                end
            end

            COMMIT: begin
                disp_d  = bcd_q[15:0];
                ovf_d   = (bcd_q[19:16] != 4'd0);
                state_d = LOAD;
            end

            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Digit selection and segment decode
    // ------------------------------------------------------------------
    assign dig = ref_q[REFRESH_BITS-1 -: 2];
    assign nib = disp_q[{dig, 2'b00} +: 4];

    // True when the selected digit and every digit above it are zero
    always_comb begin
        lead_zero = 1'b0;
        unique case (dig)
            2'd3:    lead_zero = (disp_q[15:12] == 4'd0);
            2'd2:    lead_zero = (disp_q[15:8]  == 8'd0);
            2'd1:    lead_zero = (disp_q[15:4]  == 12'd0);
            default: lead_zero = 1'b0;
        endcase
    end

    always_comb begin
        seg_d = SEG_BLANK;
        if (ovf_q) begin
            seg_d = SEG_DASH;
        end else if ((BLANK_LEADING != 0) && lead_zero) begin
            seg_d = SEG_BLANK;
        end else begin
            unique case (nib)
                4'd0:    seg_d = 7'b1000000;
                4'd1:    seg_d = 7'b1111001;
                4'd2:    seg_d = 7'b0100100;
                4'd3:    seg_d = 7'b0110000;
                4'd4:    seg_d = 7'b0011001;
                4'd5:    seg_d = 7'b0010010;
                4'd6:    seg_d = 7'b0000010;
                4'd7:    seg_d = 7'b1111000;
                4'd8:    seg_d = 7'b0000000;
                4'd9:    seg_d = 7'b0010000;
                default: seg_d = SEG_BLANK;
            endcase
        end
    end

    assign an_d = ~(4'b0001 << dig);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= LOAD;
            bin_q   <= '0;
            bcd_q   <= '0;
            bit_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            ref_q   <= '0;
            seg_q   <= SEG_ZERO;
            an_q    <= AN_RESET;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            bit_q   <= bit_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            ref_q   <= ref_q + REFRESH_BITS'(1);
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign Seg = seg_q;
    assign An  = an_q;

endmodule
